gf180mcu_clkdiv_gen: RTL and testbench
======================================

Name: gf180mcu_clkdiv_gen

Overview:
- Programmable integer clock divider and glitch-free output gate that generates the divided clock feeding the clock-buffer cells of a local clock tree.
- Operates entirely on the posedge of CLK, with asynchronous active-low reset RN.
- Divide ratio and enable are sampled only at output-period boundaries, so Z never produces a runt high or low phase.
- Provides a per-period TICK strobe and a RUN status for software and sequencing logic.

Parameters:
- DW, 8, width of the divide-ratio input DIV and of the internal counter.
- RST_RUN, 0, run state after reset: 0 = stopped, 1 = running at divide ratio RST_DIV.
- RST_DIV, 2, divide ratio loaded at reset. Legal range 2 to 2^DW-1.

Ports:
- CLK  input  1  source clock; all state changes on its rising edge.
- RN  input  1  asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronous to CLK externally.
- EN  input  1  divider run request, level-sensitive.
- DIV  input  DW  requested divide ratio N.
- Z  output  1  divided clock. Registered, so it changes only just after a rising edge of CLK.
- TICK  output  1  one-CLK-cycle pulse in the cycle Z rises.
- RUN  output  1  high while the divider is producing periods.
- BUSY  output  1  high while EN or DIV is pending, not yet applied at a period boundary.

Behaviour:
- Reset (RN=0), applied asynchronously:
  - Z=0, TICK=0, BUSY=0, cnt=0.
  - nlat=RST_DIV.
  - RUN=RST_RUN; state=RUN_S if RST_RUN, else IDLE.
- Ratio sanitising: effective N = 2 when DIV is 0 or 1; otherwise N = DIV.
- Duty cycle: Z is high for ceil(N/2) CLK cycles and low for floor(N/2) cycles. Even N gives exactly 50%.
- Counter cnt runs 0..N-1:
  - Z = 1 when cnt < ceil(N/2).
  - cnt wraps from N-1 to 0.
  - cnt==0 is the period boundary.
- State machine states: IDLE, START, RUN_S, STOP.
  - IDLE: Z=0, cnt held at 0, RUN=0. If EN=1 is sampled, latch nlat=N and go to START.
  - START: one cycle. Z rises at the next edge, cnt=0, TICK=1, RUN=1. Go to RUN_S. Latency from EN sampled high to Z high is exactly 2 CLK edges.
  - RUN_S: count. At each wrap, i.e. at the edge where cnt goes from N-1 to 0:
    - If EN=0, go to STOP.
    - Otherwise re-latch nlat from DIV, then Z rises and TICK=1.
  - STOP: Z held 0, cnt=0, RUN=0 at the same edge. Go to IDLE. The last period is always complete; no truncated high phase.
- DIV changes mid-period are ignored until the next wrap.
- BUSY=1 whenever either holds:
  - (EN != RUN) and state is not START or STOP;
  - DIV, after sanitising, differs from nlat while RUN=1.
- Simultaneous events:
  - EN falling and DIV changing in the same period: the stop wins and the new DIV is not latched.
  - EN toggling 1→0→1 within one period has no effect.
- Reset mid-period: Z drops to 0 asynchronously. This is the only permitted short phase, and clock consumers are also held in reset during it.
- TICK is registered and is never asserted in IDLE or STOP.
- No combinational path from any input to any output.

Test Plan:
- Reset with RST_RUN=0, then EN=1 and DIV=4. Required: Z first rises 2 edges after EN is sampled, then repeats 1,1,0,0. TICK pulses every 4 cycles. RUN=1.
- DIV=5 running. Required: Z pattern 1,1,1,0,0. DIV=0 and DIV=1 each give period 2, pattern 1,0.
- Running at DIV=6, change to DIV=3 at cnt=1. Required: the current 6-cycle period completes, the next period is 3 cycles (1,1,0), and BUSY is high from the change until the wrap.
- Running at DIV=8, drop EN at cnt=2. Required: Z stays high through cnt=3, low through cnt=7, then IDLE with RUN=0 and no further TICK. Minimum high phase is 4 cycles.
- Assert RN at cnt=1 while Z=1. Required: Z, TICK and RUN go to 0 without waiting for a CLK edge. After release with RST_RUN=1 and RST_DIV=2, Z toggles every CLK cycle.
- EN pulsed low for 1 cycle mid-period at DIV=4. Required: no stop and an uninterrupted 1,1,0,0 pattern.

Source files
------------

// File: rtl/gf180mcu_clkdiv_gen.sv
// Programmable integer clock divider with a glitch-free registered output.
// Ratio and enable are applied only at period boundaries, so Z never shows a runt phase.
module gf180mcu_clkdiv_gen #(
  parameter int DW      = 8,
  parameter bit RST_RUN = 1'b0,
  parameter int RST_DIV = 2
) (
  input  logic          CLK,
  input  logic          RN,
  input  logic          EN,
  input  logic [DW-1:0] DIV,
  output logic          Z,
  output logic          TICK,
  output logic          RUN,
  output logic          BUSY
);

  typedef enum logic [1:0] {IDLE, START, RUN_S, STOP} state_t;

  state_t        state_reg, state_next;
  logic [DW-1:0] cnt_reg, cnt_next;
  logic [DW-1:0] nlat_reg, nlat_next;
  logic          z_reg, z_next;
  logic          tick_reg, tick_next;
  logic          run_reg, run_next;
  logic          busy_reg, busy_next;

  logic [DW-1:0] div_san;
  logic [DW-1:0] cnt_inc;
  logic [DW-1:0] n_half;
  logic          last;

  // Ratios 0 and 1 cannot form a period with both phases, so they fold onto 2.
  assign div_san = (DIV < DW'(2)) ? DW'(2) : DIV;
  assign cnt_inc = cnt_reg + DW'(1);
  assign n_half  = (nlat_reg >> 1) + {{(DW-1){1'b0}}, nlat_reg[0]};
  assign last    = (cnt_reg == nlat_reg - DW'(1));

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_reg <= RST_RUN ? RUN_S : IDLE;
      cnt_reg   <= '0;
      nlat_reg  <= DW'(RST_DIV);
      z_reg     <= 1'b0;
      tick_reg  <= 1'b0;
      run_reg   <= RST_RUN;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      nlat_reg  <= nlat_next;
      z_reg     <= z_next;
      tick_reg  <= tick_next;
      run_reg   <= run_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (EN) state_next = START;
      START:   state_next = RUN_S;
      RUN_S:   if (last && !EN) state_next = STOP;
      STOP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next  = cnt_reg;
    nlat_next = nlat_reg;
    z_next    = 1'b0;
    tick_next = 1'b0;
    run_next  = run_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        run_next = 1'b0;
        if (EN) nlat_next = div_san;
      end
      START: begin
        cnt_next  = '0;
        z_next    = 1'b1;
        tick_next = 1'b1;
        run_next  = 1'b1;
      end
      RUN_S: begin
        run_next = 1'b1;
        if (last) begin
          cnt_next = '0;
          // A pending stop takes priority over a pending ratio change.
          if (!EN) begin
            run_next = 1'b0;
          end else begin
            nlat_next = div_san;
            z_next    = 1'b1;
            tick_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_inc;
          z_next   = (cnt_inc < n_half);
        end
      end
      STOP: begin
        cnt_next = '0;
        run_next = 1'b0;
      end
      default: begin
        cnt_next = '0;
        run_next = 1'b0;
      end
    endcase
    busy_next = ((EN != run_next) && (state_next != START) && (state_next != STOP))
             || ((div_san != nlat_next) && run_next);
  end

  assign Z    = z_reg;
  assign TICK = tick_reg;
  assign RUN  = run_reg;
  assign BUSY = busy_reg;

endmodule

// File: tb/tb_gf180mcu_clkdiv_gen.sv
// Scoreboard bench: stimulus queues expected Z/TICK/RUN/BUSY per cycle, a monitor checks them.
// Instance 0 resets stopped, instance 1 resets running at ratio 2.
module tb_gf180mcu_clkdiv_gen;

  logic       clk;
  logic       rn0, en0, z0, tick0, run0, busy0;
  logic [7:0] div0;
  logic       rn1, en1, z1, tick1, run1, busy1;
  logic [7:0] div1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         d;
    string      nm;
    logic [3:0] ex;
    logic       cb;
  } item_t;

  item_t q[$];
  item_t it;

  gf180mcu_clkdiv_gen #(.DW(8), .RST_RUN(1'b0), .RST_DIV(2)) u_dut0 (
    .CLK(clk), .RN(rn0), .EN(en0), .DIV(div0),
    .Z(z0), .TICK(tick0), .RUN(run0), .BUSY(busy0)
  );

  gf180mcu_clkdiv_gen #(.DW(8), .RST_RUN(1'b1), .RST_DIV(2)) u_dut1 (
    .CLK(clk), .RN(rn1), .EN(en1), .DIV(div1),
    .Z(z1), .TICK(tick1), .RUN(run1), .BUSY(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input int d, input string nm, input logic [3:0] ex, input logic cb);
    logic [3:0] got;
    logic [3:0] m;
    got = (d == 0) ? {z0, tick0, run0, busy0} : {z1, tick1, run1, busy1};
    m   = cb ? 4'b1111 : 4'b1110;
    n_tests++;
    if ((got & m) !== (ex & m)) begin
      n_fail++;
      $display("FAIL %s dut%0d: z/tick/run/busy got %b expected %b", nm, d, got, ex);
    end else begin
      $display("[TB] ok %s dut%0d z/tick/run/busy=%b", nm, d, got);
    end
  endtask

  task automatic push(input int d, input string nm, input logic [3:0] ex, input logic cb);
    item_t e;
    e.d = d; e.nm = nm; e.ex = ex; e.cb = cb;
    q.push_back(e);
  endtask

  // Advance one edge, then queue the expected outputs for the cycle just entered.
  task automatic cyc(input int d, input string nm, input logic [3:0] ex);
    @(posedge clk); #2;
    push(d, nm, ex, 1'b1);
  endtask

  // One full period: pat holds the Z sequence MSB-first, TICK on its first cycle.
  task automatic period(input int d, input string nm, input int n, input logic [15:0] pat);
    for (int i = 0; i < n; i++)
      cyc(d, nm, {pat[n-1-i], (i == 0), 1'b1, 1'b0});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        it = q.pop_front();
        compare(it.d, it.nm, it.ex, it.cb);
      end
    end
  end

  initial begin
    rn0 = 1'b0; en0 = 1'b0; div0 = 8'd4;
    rn1 = 1'b0; en1 = 1'b1; div1 = 8'd2;
    repeat (2) @(posedge clk); #2;
    push(0, "reset_state", 4'b0000, 1'b1);
    push(1, "reset_state_run", 4'b0010, 1'b1);
    rn0 = 1'b1;

    cyc(0, "idle", 4'b0000);
    en0 = 1'b1;
    cyc(0, "start", 4'b0000);
    repeat (2) period(0, "div4", 4, 16'b1100);

    div0 = 8'd5;
    repeat (2) period(0, "div5", 5, 16'b11100);
    div0 = 8'd0;
    repeat (2) period(0, "div0", 2, 16'b10);
    div0 = 8'd1;
    repeat (2) period(0, "div1", 2, 16'b10);

    div0 = 8'd6;
    period(0, "div6", 6, 16'b111000);
    cyc(0, "chg_c0", 4'b1110);
    cyc(0, "chg_c1", 4'b1010);
    div0 = 8'd3;
    cyc(0, "chg_busy_c2", 4'b1011);
    cyc(0, "chg_busy_c3", 4'b0011);
    cyc(0, "chg_busy_c4", 4'b0011);
    cyc(0, "chg_busy_c5", 4'b0011);
    repeat (2) period(0, "div3", 3, 16'b110);

    div0 = 8'd8;
    cyc(0, "stop_c0", 4'b1110);
    cyc(0, "stop_c1", 4'b1010);
    cyc(0, "stop_c2", 4'b1010);
    en0 = 1'b0;
    cyc(0, "stop_c3_high", 4'b1011);
    repeat (4) cyc(0, "stop_low", 4'b0011);
    cyc(0, "stop_state", 4'b0000);
    repeat (3) cyc(0, "stop_idle", 4'b0000);

    en0 = 1'b1; div0 = 8'd4;
    cyc(0, "pulse_start", 4'b0000);
    cyc(0, "pulse_c0", 4'b1110);
    cyc(0, "pulse_c1", 4'b1010);
    en0 = 1'b0;
    cyc(0, "pulse_c2", 4'b0011);
    en0 = 1'b1;
    cyc(0, "pulse_c3", 4'b0010);
    repeat (2) period(0, "pulse_after", 4, 16'b1100);

    cyc(0, "arst_c0", 4'b1110);
    cyc(0, "arst_c1", 4'b1010);
    @(negedge clk); #1;
    rn0 = 1'b0;
    #1;
    compare(0, "async_reset", 4'b0000, 1'b1);
    en0 = 1'b0;

    @(posedge clk); #2;
    push(1, "run_reset_hold", 4'b0010, 1'b1);
    rn0 = 1'b1;
    rn1 = 1'b1;
    cyc(1, "run_first", 4'b0010);
    cyc(1, "run_wrap", 4'b1110);
    cyc(1, "run_low", 4'b0010);
    repeat (3) period(1, "run_div2", 2, 16'b10);

    @(negedge clk); #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
